// File: rtl/ccr_unit.sv
// ccr_unit: 68k-style condition-code register fed by a registered ALU.
// Follows each issued op through the ALU latency and merges its flags on retire.
module ccr_unit #(
   parameter int         LATENCY   = 1,        // 1..4 cycles from issue to ALU flags
   parameter logic [4:0] RESET_CCR = 5'b00000  // {X,N,Z,V,C}
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       OP_VALID,
   input  logic [4:0] OP_MASK,
   input  logic       OP_ZSTICKY,
   input  logic       FLUSH,
   input  logic       ALU_C,
   input  logic       ALU_Z,
   input  logic       ALU_V,
   input  logic       ALU_N,
   input  logic       WR_EN,
   input  logic [4:0] WR_DATA,
   input  logic [3:0] COND,
   output logic [4:0] CCR,
   output logic       BUSY,
   output logic       COND_TRUE
);

   logic [LATENCY-1:0] vld_p;
   logic [LATENCY-1:0] zsticky_p;
   logic [4:0]         mask_p [LATENCY];
   logic               retire;
   logic [4:0]         ccr_next;

   function automatic logic [4:0] merge_flags(
      input logic [4:0] ccr,
      input logic [4:0] mask,
      input logic       zsticky,
      input logic       c,
      input logic       z,
      input logic       v,
      input logic       n
   );
      logic [4:0] res;
      res = ccr;
      if (mask[4]) res[4] = c;
      if (mask[3]) res[3] = n;
      // Sticky Z lets a multi-word result be zero only if every word was zero.
      if (mask[2]) res[2] = zsticky ? (ccr[2] & z) : z;
      if (mask[1]) res[1] = v;
      if (mask[0]) res[0] = c;
      return res;
   endfunction

   function automatic logic eval_cond(input logic [3:0] cond, input logic [4:0] ccr);
      logic n, z, v, c, r;
      n = ccr[3];
      z = ccr[2];
      v = ccr[1];
      c = ccr[0];
      r = 1'b0;
      case (cond)
         4'd0:  r = 1'b1;
         4'd1:  r = 1'b0;
         4'd2:  r = ~c & ~z;
         4'd3:  r = c | z;
         4'd4:  r = ~c;
         4'd5:  r = c;
         4'd6:  r = ~z;
         4'd7:  r = z;
         4'd8:  r = ~v;
         4'd9:  r = v;
         4'd10: r = ~n;
         4'd11: r = n;
         4'd12: r = n ~^ v;
         4'd13: r = n ^ v;
         4'd14: r = ~z & (n ~^ v);
         default: r = z | (n ^ v);
      endcase
      return r;
   endfunction

   assign retire    = vld_p[LATENCY-1];
   assign BUSY      = |vld_p;
   assign COND_TRUE = eval_cond(COND, CCR);
   assign ccr_next  = merge_flags(CCR, mask_p[LATENCY-1], zsticky_p[LATENCY-1],
                                  ALU_C, ALU_Z, ALU_V, ALU_N);

   // Descriptor pipeline: valid bits are control, mask/sticky are data.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         vld_p <= '0;
      end else if (FLUSH) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= OP_VALID;
         for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
      end
   end

   always_ff @(posedge CLK) begin
      mask_p[0]    <= OP_MASK;
      zsticky_p[0] <= OP_ZSTICKY;
      for (int i = 1; i < LATENCY; i++) begin
         mask_p[i]    <= mask_p[i-1];
         zsticky_p[i] <= zsticky_p[i-1];
      end
   end

   // Retire stage: FLUSH beats WR_EN beats the retiring update.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         CCR <= RESET_CCR;
      end else if (FLUSH) begin
         CCR <= CCR;
      end else if (WR_EN) begin
         CCR <= WR_DATA;
      end else if (retire) begin
         CCR <= ccr_next;
      end
   end

endmodule
